matrix_kbd_emu: RTL and testbench
=================================

# matrix_kbd_emu

Keypad-side emulator for the 4x4 matrix keyboard interface: observes the active-low row drive lines of a scanner and answers on active-low column lines as a physical keypad would. Key state is set by press/release events over a valid/ready handshake from a host (UART bridge or test sequencer). Used for board loopback of the scanner design and as a synthesizable stimulus model in benches.

## Interface
- `TAP_CYCLES`, default 1_000_000: hold time of a tap event in `clk` cycles (40 ms at 25 MHz); legal range 2 to 2^24-1.
- `clk` input 1: system clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `row_i` input 4: scanner row lines, active-low, asynchronous to `clk`.
- `column_o` output 4: column lines, active-low; idle high.
- `ev_valid_i` input 1: key event valid.
- `ev_ready_o` output 1: event accepted when `ev_valid_i && ev_ready_o` at a rising edge.
- `ev_key_i` input 4: key index = 4*row + col; row 0 = `row_i[0]`, col 0 = `column_o[0]`.
- `ev_press_i` input 1: 1 = press, 0 = release.
- `ev_tap_i` input 1: tap request; present only with `KBD_EMU_TAP_EN`.
- `pressed_o` output 16: current key bitmap, bit k = key k held.
- `scan_cnt_o` output 8: count of completed scans; wraps 255 -> 0.

## Operation
- Reset values: `pressed_o` 16'h0000, `column_o` 4'hF, `ev_ready_o` 1, `scan_cnt_o` 8'h00, row synchronizer flops 4'hF.
- `row_i` passes through a 2-flop synchronizer; sync output `rows_n`.
- Output register: `column_o[c]` <= 0 if any r has `rows_n[r]`==0 and `pressed[4r+c]`==1, else 1. Several low rows OR together; ghosting is not modelled.
- Accepted press event sets `pressed[ev_key_i]`. Accepted release event clears it. One event per cycle. Repeated press or release of the same key is idempotent.
- Scan counter: increments on a synchronized falling edge of `rows_n[0]` (row 0 going active). An edge-detect flop holds the previous `rows_n[0]`, reset to 1.
- Without `KBD_EMU_TAP_EN`, `ev_ready_o` is constant 1.

## Timing
- Event accepted at edge N: `pressed_o` is updated after edge N. `column_o` reflects the new key at edge N+1 if its row is already active in `rows_n`.
- `row_i` change before edge N: `rows_n` is updated at N+1 and `column_o` at N+2. Total latency is 3 cycles worst case. The scanner must hold each row for at least 4 `clk` cycles; at 40 Hz scan this is trivially met.
- `scan_cnt_o` updates 1 cycle after the `rows_n[0]` falling edge.
- Asserting reset mid-operation clears all key state and any pending tap immediately. `column_o` goes to 4'hF asynchronously.

## Configuration
- `KBD_EMU_TAP_EN` defined: adds the `ev_tap_i` port and a 24-bit down-counter.
  - An accepted press with `ev_tap_i`=1 sets the key, latches its index, and loads the counter with `TAP_CYCLES-1`.
  - `ev_ready_o` drops to 0 starting the cycle after acceptance.
  - When the counter reaches 0, the latched key is cleared and `ev_ready_o` returns to 1 in the same cycle. Total press duration is exactly `TAP_CYCLES` cycles.
  - `ev_tap_i` on a release event is ignored; it is treated as a plain release.
  - While a tap is pending, no events are accepted, so a tap and a new event cannot collide.
- Not defined: no tap port and no counter; `ev_ready_o` is tied to 1.

## Structure
- Shared package `kbd_pkg`:
  - constants `KBD_ROWS`=4, `KBD_COLS`=4;
  - `typedef logic [3:0] kbd_key_t`;
  - `typedef logic [15:0] kbd_map_t`.
  - The scanner and the emulator share the same key-index convention.
- One sub-module `kbd_sync`: parameterized-width 2-flop synchronizer with reset value all-ones. It is reused by the scanner for `column_i`.

## Test plan
- Reset with `row_i`=4'hF: `column_o`=4'hF, `pressed_o`=0, `scan_cnt_o`=0, `ev_ready_o`=1.
- Press key 6 (row 1, col 2), then drive `row_i`=4'b1101: `column_o`=4'b1011 exactly 3 cycles after the row change. With `row_i`=4'b1110, `column_o` stays 4'hF.
- Press keys 1 and 13, then `row_i`=4'b0110: `column_o`=4'b1101. Release 13: `column_o` stays 4'b1101 (key 1 still active). Release 1: `column_o`=4'hF.
- Drive row 0 active 300 times with a scan pattern of 4'b1110, 1101, 1011, 0111: `scan_cnt_o`=44 (300 mod 256).
- `KBD_EMU_TAP_EN` with `TAP_CYCLES`=10:
  - tap key 0: `pressed_o[0]` is high for exactly 10 cycles and `ev_ready_o` is low for 9 of them;
  - an event held valid during the tap is accepted on the cycle `ev_ready_o` returns to 1.
- Assert reset mid-tap with keys 3 and 15 held and row 3 active: `column_o`=4'hF asynchronously. After release, `pressed_o`=0 and `ev_ready_o`=1.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared 4x4 keypad definitions: key index = 4*row + col, used by scanner and emulator alike.
package kbd_pkg;

    localparam int KBD_ROWS  = 4;
    localparam int KBD_COLS  = 4;
    localparam int KBD_KEYS  = KBD_ROWS * KBD_COLS;
    localparam int TAP_CNT_W = 24;

    typedef logic [3:0]  kbd_key_t;
    typedef logic [15:0] kbd_map_t;

endpackage

// File: rtl/kbd_sync.sv
// Two-flop synchronizer with all-ones reset, so idle active-low lines read as inactive.
module kbd_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/matrix_kbd_emu.sv
// Keypad emulator: answers scanner row drive with column lines from a host-set key map.
// Optional timed tap events are enabled by defining KBD_EMU_TAP_EN.
module matrix_kbd_emu
    import kbd_pkg::*;
#(
    parameter int unsigned TAP_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic [KBD_ROWS-1:0] row_i,
    output logic [KBD_COLS-1:0] column_o,
    input  logic                ev_valid_i,
    output logic                ev_ready_o,
    input  kbd_key_t            ev_key_i,
    input  logic                ev_press_i,
`ifdef KBD_EMU_TAP_EN
    input  logic                ev_tap_i,
`endif
    output kbd_map_t            pressed_o,
    output logic [7:0]          scan_cnt_o
);

    logic [KBD_ROWS-1:0] rows_n;
    kbd_map_t            pressed_reg, pressed_next;
    logic [KBD_COLS-1:0] column_reg, column_next;
    logic [7:0]          scan_cnt_reg;
    logic                row0_prev_reg;
    logic                ev_fire;

    kbd_sync #(.WIDTH(KBD_ROWS)) u_row_sync (
        .clk    (clk),
        .rst_ni (rst_ni),
        .d      (row_i),
        .q      (rows_n)
    );

    assign ev_fire = ev_valid_i && ev_ready_o;

    // A column is pulled low when any active row crosses a held key in that column.
    logic [KBD_COLS-1:0][KBD_ROWS-1:0] hit;
    for (genvar gi = 0; gi < KBD_COLS; gi++) begin : g_col
        for (genvar gj = 0; gj < KBD_ROWS; gj++) begin : g_row
            assign hit[gi][gj] = !rows_n[gj] && pressed_reg[gj*KBD_COLS + gi];
        end
        assign column_next[gi] = ~|hit[gi];
    end

`ifdef KBD_EMU_TAP_EN
    localparam logic [TAP_CNT_W-1:0] TAP_LOAD = TAP_CNT_W'(TAP_CYCLES - 1);

    logic                 tap_pending_reg;
    kbd_key_t             tap_key_reg;
    logic [TAP_CNT_W-1:0] tap_cnt_reg;
    logic                 tap_done;

    assign tap_done   = tap_pending_reg && (tap_cnt_reg == '0);
    // Ready comes back in the cycle the counter hits zero so a waiting event lands on the release edge.
    assign ev_ready_o = !tap_pending_reg || tap_done;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_pending_reg <= 1'b0;
            tap_key_reg     <= '0;
            tap_cnt_reg     <= '0;
        end else if (ev_fire && ev_press_i && ev_tap_i) begin
            tap_pending_reg <= 1'b1;
            tap_key_reg     <= ev_key_i;
            tap_cnt_reg     <= TAP_LOAD;
        end else if (tap_done) begin
            tap_pending_reg <= 1'b0;
        end else if (tap_pending_reg) begin
            tap_cnt_reg <= tap_cnt_reg - 1'b1;
        end
    end
`else
    assign ev_ready_o = 1'b1;
`endif

    always_comb begin
        pressed_next = pressed_reg;
`ifdef KBD_EMU_TAP_EN
        if (tap_done) begin
            pressed_next[tap_key_reg] = 1'b0;
        end
`endif
        // A new event applies after the tap expiry so it wins on the shared edge.
        if (ev_fire) begin
            pressed_next[ev_key_i] = ev_press_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pressed_reg   <= '0;
            column_reg    <= '1;
            scan_cnt_reg  <= '0;
            row0_prev_reg <= 1'b1;
        end else begin
            pressed_reg   <= pressed_next;
            column_reg    <= column_next;
            row0_prev_reg <= rows_n[0];
            if (row0_prev_reg && !rows_n[0]) begin
                scan_cnt_reg <= scan_cnt_reg + 8'd1;
            end
        end
    end

    assign pressed_o  = pressed_reg;
    assign column_o   = column_reg;
    assign scan_cnt_o = scan_cnt_reg;

endmodule

// File: tb/tb_matrix_kbd_emu.sv
// Self-checking bench for matrix_kbd_emu: vector table, hand sequences and a random run against a key-map model.
module tb_matrix_kbd_emu;
    localparam int TAP = 10;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  row_i;
    logic [3:0]  column_o;
    logic        ev_valid_i;
    logic        ev_ready_o;
    logic [3:0]  ev_key_i;
    logic        ev_press_i;
`ifdef KBD_EMU_TAP_EN
    logic        ev_tap_i;
`endif
    logic [15:0] pressed_o;
    logic [7:0]  scan_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pressed;
    logic [3:0]  m_rows;
    logic [7:0]  m_scan;

    always #5 clk = ~clk;

    matrix_kbd_emu #(.TAP_CYCLES(TAP)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .row_i      (row_i),
        .column_o   (column_o),
        .ev_valid_i (ev_valid_i),
        .ev_ready_o (ev_ready_o),
        .ev_key_i   (ev_key_i),
        .ev_press_i (ev_press_i),
`ifdef KBD_EMU_TAP_EN
        .ev_tap_i   (ev_tap_i),
`endif
        .pressed_o  (pressed_o),
        .scan_cnt_o (scan_cnt_o)
    );

    typedef struct {
        logic [3:0]  key;
        logic        press;
        logic [3:0]  row;
        logic [3:0]  exp_col;
        logic [15:0] exp_pressed;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Physical keypad rule: a column is low when any low row line crosses a held key.
    function automatic logic [3:0] model_col(input logic [15:0] p, input logic [3:0] rows);
        logic [3:0] col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && p[r*4 + c]) col[c] = 1'b0;
        return col;
    endfunction

    task automatic set_row(input logic [3:0] r);
        if (m_rows[0] && !r[0]) m_scan = m_scan + 8'd1;
        m_rows = r;
        row_i  = r;
    endtask

    task automatic do_reset();
        ev_valid_i = 1'b0;
        row_i      = 4'hF;
        rst_ni     = 1'b0;
        tick(3);
        rst_ni    = 1'b1;
        m_pressed = '0;
        m_rows    = 4'hF;
        m_scan    = '0;
        tick(1);
    endtask

    task automatic send_ev(input logic [3:0] key, input logic press);
        int n = 0;
        ev_valid_i = 1'b1;
        ev_key_i   = key;
        ev_press_i = press;
        while (!ev_ready_o && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ev_ready_timeout: got 0 expected 1");
        end
        tick(1);
        ev_valid_i   = 1'b0;
        m_pressed[key] = press;
    endtask

`ifdef KBD_EMU_TAP_EN
    task automatic send_tap(input logic [3:0] key);
        ev_tap_i = 1'b1;
        send_ev(key, 1'b1);
        ev_tap_i = 1'b0;
    endtask
`endif

    initial begin
        ev_key_i   = '0;
        ev_press_i = 1'b0;
`ifdef KBD_EMU_TAP_EN
        ev_tap_i   = 1'b0;
`endif
        vecs[0]  = '{4'd1,  1'b1, 4'hF,    4'hF,    16'h0002};
        vecs[1]  = '{4'd13, 1'b1, 4'hF,    4'hF,    16'h2002};
        vecs[2]  = '{4'd13, 1'b1, 4'b0110, 4'b1101, 16'h2002};
        vecs[3]  = '{4'd13, 1'b0, 4'b0110, 4'b1101, 16'h0002};
        vecs[4]  = '{4'd1,  1'b0, 4'b0110, 4'hF,    16'h0000};
        vecs[5]  = '{4'd0,  1'b0, 4'b0110, 4'hF,    16'h0000};
        vecs[6]  = '{4'd10, 1'b1, 4'b1011, 4'b1011, 16'h0400};
        vecs[7]  = '{4'd11, 1'b1, 4'b1011, 4'b0011, 16'h0C00};
        vecs[8]  = '{4'd4,  1'b1, 4'b1001, 4'b0010, 16'h0C10};
        vecs[9]  = '{4'd10, 1'b0, 4'hF,    4'hF,    16'h0810};
        vecs[10] = '{4'd11, 1'b0, 4'hF,    4'hF,    16'h0010};
        vecs[11] = '{4'd4,  1'b0, 4'hF,    4'hF,    16'h0000};

        do_reset();
        check("reset_column", column_o, 4'hF);
        check("reset_pressed", pressed_o, 16'h0000);
        check("reset_scan", scan_cnt_o, 8'h00);
        check("reset_ready", ev_ready_o, 1'b1);

        // Row-to-column latency is three edges.
        send_ev(4'd6, 1'b1);
        check("key6_pressed", pressed_o, 16'h0040);
        set_row(4'b1101);
        tick(1); check("lat_edge1", column_o, 4'hF);
        tick(1); check("lat_edge2", column_o, 4'hF);
        tick(1); check("lat_edge3", column_o, 4'b1011);
        set_row(4'b1110);
        tick(4); check("key6_other_row", column_o, 4'hF);
        send_ev(4'd6, 1'b0);
        set_row(4'hF);
        tick(4);

        foreach (vecs[i]) begin
            send_ev(vecs[i].key, vecs[i].press);
            set_row(vecs[i].row);
            tick(4);
            check($sformatf("vec%0d_column", i), column_o, vecs[i].exp_col);
            check($sformatf("vec%0d_pressed", i), pressed_o, vecs[i].exp_pressed);
        end

        do_reset();
        for (int s = 0; s < 300; s++) begin
            set_row(4'b1110); tick(4);
            set_row(4'b1101); tick(4);
            set_row(4'b1011); tick(4);
            set_row(4'b0111); tick(4);
        end
        check("scan_300", scan_cnt_o, 8'd44);
        set_row(4'hF);
        tick(4);

`ifdef KBD_EMU_TAP_EN
        begin
            int hi = 0;
            int lo = 0;
            int n  = 0;
            logic rdy;
            logic acc = 1'b0;
            send_tap(4'd0);
            for (int i = 0; i < 20; i++) begin
                hi += int'(pressed_o[0]);
                lo += int'(!ev_ready_o);
                tick(1);
            end
            check("tap_press_cycles", hi, TAP);
            check("tap_ready_low_cycles", lo, TAP - 1);
            check("tap_cleared", pressed_o, 16'h0000);

            send_tap(4'd0);
            ev_valid_i = 1'b1;
            ev_key_i   = 4'd5;
            ev_press_i = 1'b1;
            while (!acc && n < 50) begin
                rdy = ev_ready_o;
                tick(1);
                n++;
                if (rdy) acc = 1'b1;
            end
            ev_valid_i = 1'b0;
            check("tap_held_accept_cycle", n, TAP);
            check("tap_held_pressed", pressed_o, 16'h0020);
            m_pressed = 16'h0020;
            send_ev(4'd5, 1'b0);
        end
`endif

        // Asynchronous reset with keys held and row 3 active.
        send_ev(4'd3, 1'b1);
        send_ev(4'd15, 1'b1);
        set_row(4'b0111);
        tick(4);
        check("prereset_column", column_o, 4'b0111);
`ifdef KBD_EMU_TAP_EN
        send_tap(4'd0);
`endif
        #2 rst_ni = 1'b0;
        #1 check("async_reset_column", column_o, 4'hF);
        row_i = 4'hF;
        tick(2);
        rst_ni    = 1'b1;
        m_pressed = '0;
        m_rows    = 4'hF;
        m_scan    = '0;
        tick(2);
        check("postreset_pressed", pressed_o, 16'h0000);
        check("postreset_ready", ev_ready_o, 1'b1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                send_ev(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                case ($urandom_range(0, 2))
                    0: set_row(4'hF);
                    1: set_row(~(4'b0001 << $urandom_range(0, 3)));
                    default: set_row(4'($urandom_range(0, 15)));
                endcase
            end
            tick(4);
            check($sformatf("rnd%0d_pressed", i), pressed_o, m_pressed);
            check($sformatf("rnd%0d_column", i), column_o, model_col(m_pressed, m_rows));
            check($sformatf("rnd%0d_scan", i), scan_cnt_o, m_scan);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
